// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving an external rf_1r1w register
// file (combinational read, registered write) as circular storage.
// Pointers are ADDRW+1 bits wide; the extra MSB is a wrap bit that separates
// full from empty when the low address bits coincide.
// Optional feature macro: FIFO_CTRL_LEVEL_EN adds a registered occupancy count
// (o_level) and a registered almost-full flag (o_almost_full). Without it both
// outputs are tied to zero and no level register exists.

module fifo_ctrl #(
    parameter int ADDRW = 4,
    parameter int DATAW = 8,
    parameter int AFULL = 2**ADDRW - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_valid,
    input  logic [DATAW-1:0] i_wr_data,
    output logic             o_wr_ready,
    output logic             o_rd_valid,
    output logic [DATAW-1:0] o_rd_data,
    input  logic             i_rd_ready,
    output logic [ADDRW-1:0] o_rf_rd_addr,
    input  logic [DATAW-1:0] i_rf_rd_data,
    output logic [ADDRW-1:0] o_rf_wr_addr,
    output logic [DATAW-1:0] o_rf_wr_data,
    output logic             o_rf_wr_en,
    output logic [ADDRW:0]   o_level,
    output logic             o_almost_full
);

    localparam logic [ADDRW:0] PTR_ONE = {{ADDRW{1'b0}}, 1'b1};

    // A threshold above the depth could never be reached; catch it at elaboration.
    if (AFULL > 2**ADDRW) begin : g_bad_afull
        $error("fifo_ctrl: AFULL exceeds FIFO depth");
    end

    logic [ADDRW:0] wr_ptr;
    logic [ADDRW:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    // Equal pointers mean empty; equal addresses with opposite wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDRW-1:0] == rd_ptr[ADDRW-1:0]) &&
                   (wr_ptr[ADDRW] != rd_ptr[ADDRW]);

    // Ready depends only on the pointers, so a pop in a full cycle does not
    // open the slot until the following cycle.
    assign o_wr_ready = !full;
    assign o_rd_valid = !empty;

    // Flush wins over both transfers. A write is also suppressed while reset
    // is asserted so a dropped push does not touch the register file either.
    assign push = i_wr_valid && !full && !i_flush && !rst;
    assign pop  = !empty && i_rd_ready && !i_flush;

    // Register-file side: head entry is read combinationally at rd_ptr, the
    // incoming word is written at the current wr_ptr.
    assign o_rf_rd_addr = rd_ptr[ADDRW-1:0];
    assign o_rd_data    = i_rf_rd_data;
    assign o_rf_wr_addr = wr_ptr[ADDRW-1:0];
    assign o_rf_wr_data = i_wr_data;
    assign o_rf_wr_en   = push;

    // Write pointer: advances on every accepted push, wrapping through the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer: snaps to wr_ptr on flush (FIFO empty), else advances on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (i_flush) begin
            rd_ptr <= wr_ptr;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    logic [ADDRW:0] level;
    logic [ADDRW:0] level_next;
    logic           almost_full;

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level;
        if (i_flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + PTR_ONE;
        end else if (pop && !push) begin
            level_next = level - PTR_ONE;
        end
    end

    // Occupancy and almost-full registered together so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_next;
            almost_full <= (int'(level_next) >= AFULL);
        end
    end

    assign o_level       = level;
    assign o_almost_full = almost_full;
`else
    assign o_level       = '0;
    assign o_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a behavioural
// register-file model and a queue-based reference FIFO. Directed scenarios
// carry hand-computed expectations; a random phase follows.

module tb_fifo_ctrl;

    localparam int ADDRW = 4;
    localparam int DATAW = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
`ifdef FIFO_CTRL_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             i_flush;
    logic             i_wr_valid;
    logic [DATAW-1:0] i_wr_data;
    logic             o_wr_ready;
    logic             o_rd_valid;
    logic [DATAW-1:0] o_rd_data;
    logic             i_rd_ready;
    logic [ADDRW-1:0] o_rf_rd_addr;
    logic [DATAW-1:0] i_rf_rd_data;
    logic [ADDRW-1:0] o_rf_wr_addr;
    logic [DATAW-1:0] o_rf_wr_data;
    logic             o_rf_wr_en;
    logic [ADDRW:0]   o_level;
    logic             o_almost_full;

    int n_cmp = 0;
    int n_err = 0;

    fifo_ctrl #(.ADDRW(ADDRW), .DATAW(DATAW), .AFULL(AFULL)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (i_flush),
        .i_wr_valid   (i_wr_valid),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .i_rd_ready   (i_rd_ready),
        .o_rf_rd_addr (o_rf_rd_addr),
        .i_rf_rd_data (i_rf_rd_data),
        .o_rf_wr_addr (o_rf_wr_addr),
        .o_rf_wr_data (o_rf_wr_data),
        .o_rf_wr_en   (o_rf_wr_en),
        .o_level      (o_level),
        .o_almost_full(o_almost_full)
    );

    // Register file: registered write, combinational read.
    logic [DATAW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (o_rf_wr_en) mem[o_rf_wr_addr] <= o_rf_wr_data;
    assign i_rf_rd_data = mem[o_rf_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding the FIFO contents in order.
    logic [DATAW-1:0] q[$];

    always begin
        bit               mpush, mpop, mflush;
        logic [DATAW-1:0] wd;
        @(negedge clk);
        if (rst) begin
            check("m_rst_rd_valid", o_rd_valid, 0);
            check("m_rst_wr_ready", o_wr_ready, 1);
            check("m_rst_level", o_level, 0);
            check("m_rst_afull", o_almost_full, 0);
            check("m_rst_wr_en", o_rf_wr_en, 0);
            q.delete();
        end else begin
            check("m_rd_valid", o_rd_valid, q.size() != 0);
            check("m_wr_ready", o_wr_ready, q.size() != DEPTH);
            if (q.size() != 0) check("m_rd_data", o_rd_data, q[0]);
            check("m_level", o_level, LVL ? q.size() : 0);
            check("m_afull", o_almost_full, LVL && (q.size() >= AFULL));
            mflush = i_flush;
            mpush  = i_wr_valid && (q.size() < DEPTH) && !i_flush;
            mpop   = i_rd_ready && (q.size() > 0) && !i_flush;
            wd     = i_wr_data;
            check("m_wr_en", o_rf_wr_en, mpush);
            if (mpush) check("m_wr_data", o_rf_wr_data, wd);
            @(posedge clk);
            if (mflush) q.delete();
            else begin
                if (mpop) void'(q.pop_front());
                if (mpush) q.push_back(wd);
            end
        end
    end

    task automatic drive(input bit wv, input logic [DATAW-1:0] wd, input bit rr, input bit fl);
        i_wr_valid = wv;
        i_wr_data  = wd;
        i_rd_ready = rr;
        i_flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DATAW-1:0] hist [64];

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        #2;
        check("reset_rd_valid", o_rd_valid, 0);
        check("reset_wr_ready", o_wr_ready, 1);
        check("reset_level", o_level, 0);
        check("reset_afull", o_almost_full, 0);

        // Fill 0x00..0x0F with no pops.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, DATAW'(i), 0, 0);
            #2;
            check("fill_wr_en", o_rf_wr_en, 1);
            check("fill_level", o_level, LVL ? i : 0);
            check("fill_afull", o_almost_full, LVL && i >= 14);
            tick();
        end
        drive(1, 8'h99, 0, 0);
        #2;
        check("full_wr_ready", o_wr_ready, 0);
        check("full_wr_en", o_rf_wr_en, 0);
        check("full_level", o_level, LVL ? 16 : 0);
        check("full_afull", o_almost_full, LVL);
        tick();

        // Full with push and pop together: only the pop happens.
        drive(1, 8'h77, 1, 0);
        #2;
        check("fullpp_wr_en", o_rf_wr_en, 0);
        check("fullpp_rd_data", o_rd_data, 8'h00);
        tick();
        drive(0, 0, 0, 0);
        #2;
        check("fullpp_wr_ready", o_wr_ready, 1);
        check("fullpp_level", o_level, LVL ? 15 : 0);

        // Drain the rest in order.
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, 1, 0);
            #2;
            check("drain_rd_valid", o_rd_valid, 1);
            check("drain_rd_data", o_rd_data, i);
            tick();
        end
        drive(0, 0, 0, 0);
        #2;
        check("drain_empty", o_rd_valid, 0);

        // Half-full streaming: 8 preloaded, then 40 cycles of push+pop.
        for (int i = 0; i < 48; i++) hist[i] = DATAW'($urandom);
        for (int i = 0; i < 8; i++) begin
            drive(1, hist[i], 0, 0);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1, hist[k+8], 1, 0);
            #2;
            check("stream_rd_data", o_rd_data, hist[k]);
            check("stream_level", o_level, LVL ? 8 : 0);
            tick();
        end
        for (int k = 40; k < 48; k++) begin
            drive(0, 0, 1, 0);
            #2;
            check("stream_tail", o_rd_data, hist[k]);
            tick();
        end
        drive(0, 0, 0, 0);
        #2;
        check("stream_empty", o_rd_valid, 0);

        // No bypass: word is visible only the cycle after its push.
        drive(1, 8'hA5, 0, 0);
        #2;
        check("a5_push_cycle_valid", o_rd_valid, 0);
        tick();
        drive(0, 0, 0, 0);
        #2;
        check("a5_next_valid", o_rd_valid, 1);
        check("a5_next_data", o_rd_data, 8'hA5);
        drive(0, 0, 1, 0);
        tick();

        // Flush with 5 entries and a concurrent write request.
        for (int i = 0; i < 5; i++) begin
            drive(1, DATAW'(8'h50 + i), 0, 0);
            tick();
        end
        drive(1, 8'h3C, 0, 1);
        #2;
        check("flush_wr_en", o_rf_wr_en, 0);
        tick();
        drive(0, 0, 0, 0);
        #2;
        check("flush_rd_valid", o_rd_valid, 0);
        check("flush_wr_ready", o_wr_ready, 1);
        check("flush_level", o_level, 0);

        // Random traffic with alternating push/pop bias.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 120; c++) begin
                bit wv, rr, fl;
                wv = (seg % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
                rr = (seg % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
                fl = ($urandom_range(0, 59) == 0);
                drive(wv, DATAW'($urandom), rr, fl);
                tick();
            end
        end

        // Reset mid-stream: outputs return to reset values immediately.
        drive(0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, DATAW'(8'hC0 + i), 0, 0);
            tick();
        end
        rst = 1'b1;
        #2;
        check("midrst_rd_valid", o_rd_valid, 0);
        check("midrst_wr_ready", o_wr_ready, 1);
        check("midrst_level", o_level, 0);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        check("postrst_rd_valid", o_rd_valid, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
